pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//   Sequences the program counter and instruction-memory fetch handshake for the CPU front end.
//   Issues sequential fetch requests, applies branch and flush redirects, and honours pipeline stalls.
//   Delivers {instruction, PC, valid} to the IF/ID stage.
//   Sits between the instruction memory port and the IF/ID register.
// PARAMETERS
//   ADDR_WIDTH    32   PC / instruction address width (bits)
//   DATA_WIDTH    32   instruction word width (bits)
//   RESET_VECTOR  0    first fetch address after reset
// PORTS
//   clock           in   1           single clock; all state updates on posedge
//   reset           in   1           asynchronous, active-high
//   stall_req       in   1           downstream stall; hold IF/ID outputs, launch no new fetch
//   branch_flag     in   1           redirect to branch_target
//   branch_target   in   ADDR_WIDTH  branch destination
//   flush_flag      in   1           redirect to flush_target, discard held instruction (beats branch)
//   flush_target    in   ADDR_WIDTH  exception/flush destination
//   inst_req        out  1           fetch request to instruction memory
//   inst_addr       out  ADDR_WIDTH  fetch address; stable while inst_req=1 and no ack
//   inst_ack        in   1           memory accepted request; inst_rdata valid this cycle
//   inst_rdata      in   DATA_WIDTH  fetched word
//   chip_enable     out  1           0 during the cycle after reset release, 1 otherwise
//   inst_out        out  DATA_WIDTH  instruction to IF/ID
//   inst_pc_out     out  ADDR_WIDTH  PC of inst_out
//   inst_valid      out  1           inst_out/inst_pc_out hold a live instruction
//   misalign_fault  out  1           see CONFIGURATION
//   fault_addr      out  ADDR_WIDTH  see CONFIGURATION
// BEHAVIOUR
// - Reset (async) values:
//   - state=IDLE, inst_addr=RESET_VECTOR; inst_req, chip_enable, inst_valid, misalign_fault=0.
//   - inst_out, inst_pc_out, fault_addr=0; pending redirect and skid buffer cleared.
// - States:
//   - IDLE: first posedge after reset release -> chip_enable=1, state REQ.
//   - REQ: inst_req=1; inst_addr never changes until a posedge with inst_ack=1.
//     - Ack with stall_req=0 and no redirect: next cycle inst_out=inst_rdata, inst_pc_out=inst_addr,
//       inst_valid=1, inst_addr+=4. Latency ack->valid = 1 cycle.
//     - Back-to-back acks give one instruction per cycle.
//     - No ack and stall_req=0 -> inst_valid=0 next cycle.
//   - HOLD: inst_req=0. Entered on ack with stall_req=1; word+PC go to a 1-entry skid buffer.
//     On stall_req=0: skid -> outputs, inst_addr+=4, state REQ.
// - stall_req=1: inst_out/inst_pc_out/inst_valid hold. An outstanding request is not withdrawn.
// - Redirects (priority flush > branch > stall > sequential):
//   - In REQ without ack: latch target into pending register; a later flush overwrites a pending branch.
//     On ack: discard rdata, inst_addr=pending target, clear pending, stay REQ.
//   - Redirect with ack in the same cycle: discard rdata, inst_addr=new target.
//   - In IDLE/HOLD: inst_addr=target next cycle, skid cleared, state REQ (IDLE still waits one cycle).
//   - flush_flag additionally forces inst_valid=0 next cycle, even when stall_req=1.
//   - branch_flag leaves the current outputs untouched.
// - Arithmetic: inst_addr+4 modulo 2^ADDR_WIDTH (0xFFFF_FFFC -> 0x0000_0000); no fault on wrap.
// - Reset mid-request: inst_req drops immediately; the memory tolerates abandoned requests.
// CONFIGURATION
// - PC_ALIGN_CHECK_EN defined:
//   - A redirect target with addr[1:0]!=0 is not fetched.
//   - misalign_fault pulses 1 cycle, fault_addr=target, state HOLD with inst_req=0.
//   - Only a subsequent aligned flush_flag restarts fetch.
// - PC_ALIGN_CHECK_EN undefined: target[1:0] forced to 00; misalign_fault and fault_addr tied 0.
// TESTING
// 1. Reset release, ack every cycle
//    -> chip_enable 0 then 1; inst_addr 0,4,8,C; inst_valid from cycle 3 with matching inst_pc_out.
// 2. Ack delayed 3 cycles
//    -> inst_addr stable at 0x8 throughout; inst_valid=0 for those cycles; inst_valid 1 cycle after ack.
// 3. stall_req=1 for 4 cycles while ack arrives at 0x10
//    -> outputs frozen, inst_req=0; on release inst_pc_out=0x10, next fetch 0x14.
// 4. branch_flag (target 0x100) during pending request at 0x20, ack 2 cycles later
//    -> 0x20 data discarded, next inst_addr=0x100.
// 5. flush_flag (0x180) and branch_flag (0x100) same cycle
//    -> inst_valid=0 next cycle, fetch 0x180.
//    Start PC 0xFFFF_FFFC -> next fetch 0x0.
// 6. PC_ALIGN_CHECK_EN, branch target 0x102
//    -> misalign_fault=1 one cycle, fault_addr=0x102, inst_req=0 until flush to 0x180.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer and instruction-memory fetch handshake feeding the IF/ID register.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets; otherwise their low bits are masked.
module pc_fetch_ctrl #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall_req,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  flush_flag,
    input  logic [ADDR_WIDTH-1:0] flush_target,
    output logic                  inst_req,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_ack,
    input  logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  chip_enable,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc_out,
    output logic                  inst_valid,
    output logic                  misalign_fault,
    output logic [ADDR_WIDTH-1:0] fault_addr
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    chip_en_q, chip_en_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    valid_q, valid_d;
    logic                    pend_q, pend_d;
    logic                    pend_flush_q, pend_flush_d;
    logic [ADDR_WIDTH-1:0]   pend_tgt_q, pend_tgt_d;
    logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [ADDR_WIDTH-1:0]   skid_pc_q, skid_pc_d;
    logic                    fault_q, fault_d;
    logic [ADDR_WIDTH-1:0]   fault_addr_q, fault_addr_d;
    logic                    lock_q, lock_d;

    logic                    redir;
    logic [ADDR_WIDTH-1:0]   tgt;
    logic                    misaligned;
    logic                    deliver;
    logic [DATA_WIDTH-1:0]   deliv_data;
    logic [ADDR_WIDTH-1:0]   deliv_pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= RESET_VECTOR;
            chip_en_q    <= 1'b0;
            out_q        <= '0;
            pc_q         <= '0;
            valid_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_flush_q <= 1'b0;
            pend_tgt_q   <= '0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            chip_en_q    <= chip_en_d;
            out_q        <= out_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            pend_flush_q <= pend_flush_d;
            pend_tgt_q   <= pend_tgt_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            lock_q       <= lock_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        chip_en_d    = chip_en_q;
        out_d        = out_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        pend_d       = pend_q;
        pend_flush_d = pend_flush_q;
        pend_tgt_d   = pend_tgt_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;
        lock_d       = lock_q;
        deliver      = 1'b0;
        deliv_data   = '0;
        deliv_pc     = '0;
        misaligned   = 1'b0;

        redir = flush_flag || branch_flag;
        tgt   = flush_flag ? flush_target : branch_target;
`ifdef PC_ALIGN_CHECK_EN
        misaligned = redir && (tgt[1:0] != 2'b00);
`else
        tgt[1:0] = 2'b00;
`endif

        // A trapped target parks the fetcher; while locked only a flush is honoured.
        if (misaligned && (!lock_q || flush_flag)) begin
            fault_d      = 1'b1;
            fault_addr_d = tgt;
            state_d      = HOLD;
            lock_d       = 1'b1;
            chip_en_d    = 1'b1;
            pend_d       = 1'b0;
            skid_data_d  = '0;
            skid_pc_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    chip_en_d = 1'b1;
                    state_d   = REQ;
                    if (redir) addr_d = tgt;
                end
                REQ: begin
                    if (inst_ack) begin
                        if (redir) begin
                            addr_d = tgt;
                            pend_d = 1'b0;
                        end else if (pend_q) begin
                            addr_d = pend_tgt_q;
                            pend_d = 1'b0;
                        end else if (stall_req) begin
                            skid_data_d = inst_rdata;
                            skid_pc_d   = addr_q;
                            state_d     = HOLD;
                        end else begin
                            deliver    = 1'b1;
                            deliv_data = inst_rdata;
                            deliv_pc   = addr_q;
                            addr_d     = addr_q + ADDR_WIDTH'(4);
                        end
                    end else if (redir && (flush_flag || !pend_q || !pend_flush_q)) begin
                        pend_d       = 1'b1;
                        pend_flush_d = flush_flag;
                        pend_tgt_d   = tgt;
                    end
                end
                HOLD: begin
                    if (lock_q ? flush_flag : redir) begin
                        addr_d      = tgt;
                        lock_d      = 1'b0;
                        skid_data_d = '0;
                        skid_pc_d   = '0;
                        state_d     = REQ;
                    end else if (!lock_q && !stall_req) begin
                        deliver    = 1'b1;
                        deliv_data = skid_data_q;
                        deliv_pc   = skid_pc_q;
                        addr_d     = addr_q + ADDR_WIDTH'(4);
                        state_d    = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Flush kills the IF/ID slot even under stall; otherwise a stall freezes it.
        if (flush_flag) begin
            valid_d = 1'b0;
        end else if (!stall_req) begin
            valid_d = deliver;
            if (deliver) begin
                out_d = deliv_data;
                pc_d  = deliv_pc;
            end
        end
    end

    always_comb begin
        inst_req = (state_q == REQ);
    end

    assign inst_addr      = addr_q;
    assign chip_enable    = chip_en_q;
    assign inst_out       = out_q;
    assign inst_pc_out    = pc_q;
    assign inst_valid     = valid_q;
    assign misalign_fault = fault_q;
    assign fault_addr     = fault_addr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a transaction-level model predicts fetch addresses and the delivered instruction stream.
module tb_pc_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_req, branch_flag, flush_flag, inst_ack;
    logic [31:0] branch_target, flush_target, inst_rdata;
    logic        inst_req, chip_enable, inst_valid, misalign_fault;
    logic [31:0] inst_addr, inst_out, inst_pc_out, fault_addr;

    pc_fetch_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
        .clock(clock), .reset(reset), .stall_req(stall_req),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .flush_flag(flush_flag), .flush_target(flush_target),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .chip_enable(chip_enable), .inst_out(inst_out), .inst_pc_out(inst_pc_out),
        .inst_valid(inst_valid), .misalign_fault(misalign_fault), .fault_addr(fault_addr)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] pc; logic [31:0] data; } item_t;
    typedef struct { logic [31:0] addr; bit req; bit valid; } cyc_t;

    int    n_checks = 0;
    int    n_err    = 0;
    bit    mon_en   = 0;
    item_t exp_q[$];
    cyc_t  cyc_q[$];

    // Model: where the next fetch goes, a redirect waiting for the in-flight fetch, a parked word.
    bit          m_started, m_fetching, m_valid, m_redirect_is_flush;
    logic [31:0] m_pc;
    logic [31:0] m_redirect[$];
    item_t       m_parked[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [31:0] tgt;
        bit          redir;
        bit          have;
        item_t       got;
        redir = flush_flag || branch_flag;
        tgt   = flush_flag ? flush_target : branch_target;
        tgt   = tgt & 32'hFFFF_FFFC;
        have  = 0;
        got   = '{pc: 32'h0, data: 32'h0};
        if (!m_started) begin
            m_started  = 1;
            m_fetching = 1;
            if (redir) m_pc = tgt;
        end else if (m_fetching) begin
            if (inst_ack) begin
                if (redir) begin
                    m_pc = tgt;
                    m_redirect.delete();
                end else if (m_redirect.size() > 0) begin
                    m_pc = m_redirect.pop_front();
                end else if (stall_req) begin
                    m_parked.push_back('{pc: m_pc, data: inst_rdata});
                    m_fetching = 0;
                end else begin
                    got  = '{pc: m_pc, data: inst_rdata};
                    have = 1;
                    m_pc = m_pc + 32'd4;
                end
            end else if (redir) begin
                if (flush_flag || m_redirect.size() == 0 || !m_redirect_is_flush) begin
                    m_redirect.delete();
                    m_redirect.push_back(tgt);
                    m_redirect_is_flush = flush_flag;
                end
            end
        end else begin
            if (redir) begin
                m_pc = tgt;
                m_parked.delete();
                m_fetching = 1;
            end else if (!stall_req) begin
                got        = m_parked.pop_front();
                have       = 1;
                m_pc       = m_pc + 32'd4;
                m_fetching = 1;
            end
        end
        if (flush_flag) m_valid = 0;
        else if (!stall_req) begin
            m_valid = have;
            if (have) exp_q.push_back(got);
        end
        cyc_q.push_back('{addr: m_pc, req: m_fetching, valid: m_valid});
    endtask

    // Drive one cycle's inputs at the falling edge, predict the next rising edge, then wait a cycle.
    task automatic step(input bit st, input bit br, input logic [31:0] bt,
                        input bit fl, input logic [31:0] ft, input bit ack_want);
        stall_req     = st;
        branch_flag   = br;
        branch_target = bt;
        flush_flag    = fl;
        flush_target  = ft;
        inst_ack      = ack_want && m_started && m_fetching;
        inst_rdata    = $urandom;
        model_update();
        mon_en = 1;
        @(negedge clock);
    endtask

    initial begin : monitor
        cyc_t  c;
        item_t last;
        bit    prev_stall;
        last = '{pc: 32'h0, data: 32'h0};
        forever begin
            @(posedge clock);
            prev_stall = stall_req;
            #1;
            if (mon_en && cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("inst_addr", inst_addr, c.addr);
                check("inst_req", {31'b0, inst_req}, {31'b0, c.req});
                check("inst_valid", {31'b0, inst_valid}, {31'b0, c.valid});
                check("chip_enable", {31'b0, chip_enable}, 32'd1);
                if (inst_valid === 1'b1) begin
                    if (!prev_stall) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_err++;
                            $display("FAIL deliver: got pc %h with no instruction expected", inst_pc_out);
                        end else begin
                            last = exp_q.pop_front();
                        end
                    end
                    check("inst_pc_out", inst_pc_out, last.pc);
                    check("inst_out", inst_out, last.data);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] t;
        reset = 1'b1;
        stall_req = 0; branch_flag = 0; flush_flag = 0; inst_ack = 0;
        branch_target = 0; flush_target = 0; inst_rdata = 0;
        m_started = 0; m_fetching = 0; m_valid = 0; m_pc = 32'h0; m_redirect_is_flush = 0;
        repeat (2) @(negedge clock);
        check("rst inst_req", {31'b0, inst_req}, 32'd0);
        check("rst chip_enable", {31'b0, chip_enable}, 32'd0);
        check("rst inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst inst_addr", inst_addr, 32'h0);
        check("rst inst_out", inst_out, 32'h0);
        check("rst inst_pc_out", inst_pc_out, 32'h0);
        check("rst misalign_fault", {31'b0, misalign_fault}, 32'd0);
        check("rst fault_addr", fault_addr, 32'h0);
        reset = 1'b0;
        #1 check("chip_enable after release", {31'b0, chip_enable}, 32'd0);

        // Sequential fetch with ack every cycle.
        repeat (6) step(0, 0, 0, 0, 0, 1);
        // Ack delayed three cycles.
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        // Stall across an ack, then release.
        step(1, 0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 1);
        // Branch while a request is pending, ack two cycles later.
        step(0, 1, 32'h100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        // Flush beats branch in the same cycle.
        step(0, 1, 32'h100, 1, 32'h180, 1);
        repeat (2) step(0, 0, 0, 0, 0, 1);
        // Pending flush is not overwritten by a later branch.
        step(0, 0, 0, 1, 32'h240, 0);
        step(0, 1, 32'h300, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 1);
        // Address wrap past the top of memory.
        step(0, 0, 0, 1, 32'hFFFF_FFF8, 1);
        repeat (4) step(0, 0, 0, 0, 0, 1);
`ifndef PC_ALIGN_CHECK_EN
        step(0, 1, 32'h0000_0403, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                            : ($urandom & 32'h0000_FFFC);
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 11) == 0, t,
                 $urandom_range(0, 24) == 0, ($urandom & 32'h0000_FFFC),
                 $urandom_range(0, 9) < 6);
        end

        // Abandoned request: reset asynchronously mid-request.
        repeat (2) step(0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #2 mon_en = 0;
        check("req before reset", {31'b0, inst_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("req drops on reset", {31'b0, inst_req}, 32'd0);
        check("valid drops on reset", {31'b0, inst_valid}, 32'd0);
        check("addr on reset", inst_addr, 32'h0);

`ifdef PC_ALIGN_CHECK_EN
        @(negedge clock);
        reset = 1'b0; stall_req = 0; branch_flag = 0; flush_flag = 0; inst_ack = 0;
        repeat (2) @(negedge clock);
        branch_flag = 1; branch_target = 32'h102;
        @(posedge clock); #1;
        check("misalign pulse", {31'b0, misalign_fault}, 32'd1);
        check("fault_addr", fault_addr, 32'h102);
        check("req off after fault", {31'b0, inst_req}, 32'd0);
        @(negedge clock);
        branch_flag = 1; branch_target = 32'h200;
        @(posedge clock); #1;
        check("misalign one cycle", {31'b0, misalign_fault}, 32'd0);
        check("branch ignored while locked", {31'b0, inst_req}, 32'd0);
        @(negedge clock);
        branch_flag = 0;
        repeat (2) @(negedge clock);
        check("still parked", {31'b0, inst_req}, 32'd0);
        flush_flag = 1; flush_target = 32'h180;
        @(posedge clock); #1;
        check("restart req", {31'b0, inst_req}, 32'd1);
        check("restart addr", inst_addr, 32'h180);
        @(negedge clock);
        flush_flag = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
